// File: rtl/risc16_prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the RISC16 program loader.
// master = stream source / imem observer, slave = the loader.
interface risc16_prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/risc16_prog_loader.sv
// Boot loader: parses A5/N/2N data/XOR frames into 16-bit words, writes them to
// instruction memory and releases the core only after the checksum matches.
module risc16_prog_loader #(
  parameter int ADDR_W     = 4,
  parameter int WORD_COUNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  risc16_prog_loader_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 core_run
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_CNT  = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [7:0] MAX_N  = 8'(WORD_COUNT);
  localparam logic [7:0] HEADER = 8'hA5;

  logic [2:0]        state_reg;
  logic [7:0]        count_reg;
  logic [7:0]        idx_reg;
  logic [7:0]        csum_reg;
  logic [7:0]        hi_reg;
  logic              imem_we_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic [15:0]       imem_wdata_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              core_run_reg;

  logic              in_ready_w;
  logic              accept;
  logic [7:0]        idx_next;

  assign in_ready_w = (state_reg == S_HDR) || (state_reg == S_CNT) ||
                      (state_reg == S_HI)  || (state_reg == S_LO)  ||
                      (state_reg == S_CHK);
  assign accept     = bus.in_valid && in_ready_w;
  assign idx_next   = idx_reg + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      count_reg      <= '0;
      idx_reg        <= '0;
      csum_reg       <= '0;
      hi_reg         <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      core_run_reg   <= 1'b0;
    end else begin
      // The write strobe is a one-cycle pulse following each LO accept.
      imem_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg    <= S_HDR;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            core_run_reg <= 1'b0;
            busy_reg     <= 1'b1;
            idx_reg      <= '0;
            csum_reg     <= '0;
          end
        end
        S_HDR: begin
          if (accept && bus.in_data == HEADER) begin
            state_reg <= S_CNT;
          end
        end
        S_CNT: begin
          if (accept) begin
            if (bus.in_data == 8'd0 || bus.in_data > MAX_N) begin
              state_reg    <= S_ERR;
              err_reg      <= 1'b1;
              busy_reg     <= 1'b0;
              core_run_reg <= 1'b0;
            end else begin
              count_reg <= bus.in_data;
              state_reg <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_reg    <= bus.in_data;
            csum_reg  <= csum_reg ^ bus.in_data;
            state_reg <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            csum_reg       <= csum_reg ^ bus.in_data;
            imem_we_reg    <= 1'b1;
            imem_addr_reg  <= idx_reg[ADDR_W-1:0];
            imem_wdata_reg <= {hi_reg, bus.in_data};
            idx_reg        <= idx_next;
            state_reg      <= (idx_next == count_reg) ? S_CHK : S_HI;
          end
        end
        S_CHK: begin
          if (accept) begin
            busy_reg <= 1'b0;
            if (bus.in_data == csum_reg) begin
              state_reg    <= S_DONE;
              done_reg     <= 1'b1;
              core_run_reg <= 1'b1;
            end else begin
              state_reg    <= S_ERR;
              err_reg      <= 1'b1;
              core_run_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err            = err_reg;
  assign core_run       = core_run_reg;

endmodule

// File: doc/risc16_prog_loader.md
Name: risc16_prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the RISC 16-bit core.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words.
- Writes those words into the core's instruction memory, verifies an XOR checksum, and only then releases the core via core_run.
- The core stays held whenever no valid program has been loaded.

Parameters:
- ADDR_W, 4: instruction memory address width.
- WORD_COUNT, 16: maximum number of instruction words; must be ≤ 2^ADDR_W and ≤ 255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load.
- in_valid  input  1  input byte valid.
- in_data  input  8  input byte.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  instruction memory write address.
- imem_wdata  output  16  instruction word to write.
- busy  output  1  load in progress.
- done  output  1  a program was loaded and its checksum matched.
- err  output  1  the last load failed.
- core_run  output  1  releases the core (core runs when high).

Behaviour:
- All outputs are registered except in_ready, which is decoded from the current state.
- Reset (rst_n low, asynchronous) sends the FSM to IDLE and clears imem_we, imem_addr, imem_wdata, busy, done, err, core_run, the byte counter and the checksum to 0.
- Reset mid-load abandons the frame; words already written stay in memory but core_run stays 0.
- A byte is accepted on a cycle with in_valid && in_ready; no other cycle consumes data.
- Frame format: 0xA5 header, then count N, then 2N data bytes (high byte first), then checksum = XOR of the 2N data bytes.
- States: IDLE, HDR, CNT, HI, LO, CHK, DONE, ERR.
- in_ready is 1 in HDR, CNT, HI, LO and CHK, and 0 in IDLE, DONE and ERR.
- start in IDLE, DONE or ERR:
  - go to HDR next cycle;
  - clear done, err and core_run, set busy, reset word index and checksum.
- start in any other state is ignored.
- HDR: an accepted 0xA5 goes to CNT; any other accepted byte is discarded and the FSM stays in HDR (resync).
- CNT: accept N.
  - N = 0 or N > WORD_COUNT goes to ERR.
  - Otherwise store N and go to HI.
- HI: accept the byte into the high half, XOR it into the checksum, go to LO.
- LO, on accept:
  - XOR the byte into the checksum.
  - Next cycle, pulse imem_we = 1 for exactly one cycle with imem_addr = word index and imem_wdata = {hi, lo}.
  - Increment the word index.
  - If the index has now reached N, go to CHK; else go to HI.
- Address increments one per word starting at 0; it never wraps, because N ≤ WORD_COUNT.
- CHK, on accept:
  - If the byte equals the checksum, go to DONE.
  - Else go to ERR.
- DONE: done = 1, core_run = 1, busy = 0; all three take effect the cycle after the checksum byte is accepted.
- ERR: err = 1, busy = 0, core_run = 0.
- Maximum rate is one byte per cycle, with no bubbles required between bytes.
- A last-word imem_we pulse and the CHK acceptance may fall in the same cycle; both must happen.
- start arriving in the same cycle as a final CHK accept is ignored, since the FSM is not yet in DONE.

Test Plan:
- Reset then start; send A5 02 12 34 AB CD 40 → writes addr 0 = 0x1234, addr 1 = 0xABCD, one imem_we cycle each; done = 1, core_run = 1 the cycle after 0x40; err = 0.
- Same frame with checksum 0x41 → both words written, err = 1, core_run = 0, done = 0.
- Garbage bytes 00 FF 5A before A5 01 80 01 81 → garbage discarded, addr 0 = 0x8001, done = 1.
- Count 0x00, and separately count 0x11 with WORD_COUNT = 16 → ERR next cycle, no imem_we, core_run = 0.
- in_valid toggled every other cycle during a 16-word load → all 16 addresses 0..15 written in order, no duplicate or missing writes.
- Assert rst_n low mid-word after a HI byte → all outputs 0 immediately; a later start plus a valid frame loads cleanly.
- Assert start while in HI → ignored, load continues; start in DONE → core_run drops next cycle and busy rises.
